or1200_vlx_stu: RTL
===================

OR1200_VLX_STU -- requirements
Module: or1200_vlx_stu

Interface
REQ-001 The module SHALL have parameter FIFO_DEPTH, default 8, meaning byte-FIFO entries (power of 2, >=4).
REQ-002 The module SHALL have parameter STUFF_EN, default 1, meaning insert 0x00 after every emitted 0xFF byte when 1.
REQ-003 The module SHALL have parameter ADDR_W, default 32, meaning store address width.
REQ-004 The module SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 The module SHALL have port rst_i  input  1  asynchronous, active-low reset (0 = reset).
REQ-006 The module SHALL have port set_init_addr_i  input  1  load vlx_addr_o from dat_i[ADDR_W-1:0].
REQ-007 The module SHALL have port dat_i  input  32  code bits (right-aligned) or initial address.
REQ-008 The module SHALL have port len_i  input  6  number of valid bits in dat_i for push_i.
REQ-009 The module SHALL have port push_i  input  1  append len_i bits; accepted when push_i & ready_o.
REQ-010 The module SHALL have port flush_i  input  1  end of stream; accepted when flush_i & ready_o.
REQ-011 The module SHALL have port ack_i  input  1  current byte store completed.
REQ-012 The module SHALL have port ready_o  output  1  push/flush may be accepted this cycle.
REQ-013 The module SHALL have port vlx_addr_o  output  ADDR_W  address of current byte store.
REQ-014 The module SHALL have port dat_o  output  8  byte being stored (FIFO head).
REQ-015 The module SHALL have port store_byte_o  output  1  byte store request pending.
REQ-016 The module SHALL have port last_byte_o  output  1  current byte is the final byte of a flushed stream.
REQ-017 The module SHALL have port busy_o  output  1  state != IDLE.
REQ-018 The module SHALL have port done_o  output  1  one-cycle pulse when flush fully drained.

Function
REQ-019 Bits SHALL be packed MSB-first: dat_i[len_i-1] first; len_i=0 is a no-op; len_i>32 SHALL be treated as 32.
REQ-020 A 39-bit accumulator SHALL hold residual bits; ready_o = (acc_cnt<8) & state in {IDLE,RUN}.
REQ-021 Each cycle with acc_cnt>=8 and >=2 free FIFO entries, the top byte SHALL move to the FIFO; if byte==0xFF and STUFF_EN=1, 0x00 SHALL be enqueued in the same cycle.
REQ-022 store_byte_o SHALL equal FIFO non-empty; dat_o and vlx_addr_o SHALL hold stable until ack_i.
REQ-023 On ack_i & store_byte_o, FIFO SHALL pop and vlx_addr_o SHALL increment by 1, wrapping 2^ADDR_W-1 -> 0; back-to-back stores without idle cycle allowed; ack_i without store_byte_o SHALL be ignored.
REQ-024 set_init_addr_i SHALL be honoured only when busy_o=0; push_i/flush_i in the same cycle as an honoured set_init_addr_i SHALL be ignored.
REQ-025 States: IDLE (empty) -> RUN on accepted push with len_i>0; RUN -> FLUSH on accepted flush; FLUSH pads residual (acc_cnt mod 8 != 0) with 1s to byte boundary, enqueues it -> DRAIN; DRAIN -> IDLE on ack of last byte, with done_o pulse that cycle+1.
REQ-026 Flush in IDLE SHALL pulse done_o next cycle with no store; flush with zero residual SHALL add no pad byte.
REQ-027 last_byte_o SHALL be high with store_byte_o only for the final FIFO byte of a flush (the stuffed 0x00 if last data byte was 0xFF).
REQ-028 No bit SHALL be lost or duplicated under any ack_i backpressure.

Reset
REQ-029 rst_i=0 SHALL immediately, without a clock edge, clear accumulator, FIFO, state=IDLE, vlx_addr_o=0, dat_o=0, store_byte_o=0, last_byte_o=0, busy_o=0, done_o=0, ready_o=0.
REQ-030 ready_o SHALL be 1 in the first cycle after rst_i deasserts; reset mid-transfer SHALL discard all buffered data.

Verification
REQ-031 set_init_addr 0x1000; push 0xABCD len16; flush; ack every cycle -> 0xAB@0x1000, 0xCD@0x1001 with last_byte_o, done_o pulse, busy_o=0.
REQ-032 STUFF_EN=1: push 0xFF len8, push 0x3 len2, flush -> 0xFF,0x00,0xFF,0x00(last) at A..A+3; STUFF_EN=0 -> 0xFF,0xFF(last).
REQ-033 push 0x5 len3, push 0x1F len5, flush -> single byte 0xBF, last_byte_o=1, no pad byte.
REQ-034 ack_i held low 20 cycles while pushing 32-bit words -> dat_o/vlx_addr_o stable, ready_o drops when FIFO full, full byte sequence intact after release.
REQ-035 set_init_addr 0xFFFFFFFF; push 0x1234 len16; flush -> 0x12@0xFFFFFFFF, 0x34@0x00000000.
REQ-036 rst_i low mid-store -> store_byte_o=0 and vlx_addr_o=0 asynchronously; later flush in IDLE -> done_o only.

Source files
------------

// File: rtl/or1200_vlx_stu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | or1200_vlx_stu : MSB-first VLC bit packer with optional 0xFF stuffing and |
// |                  a sequential byte-store address generator                |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module or1200_vlx_stu #(
  parameter int FIFO_DEPTH = 8,
  parameter bit STUFF_EN   = 1'b1,
  parameter int ADDR_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              set_init_addr_i,
  input  logic [31:0]       dat_i,
  input  logic [5:0]        len_i,
  input  logic              push_i,
  input  logic              flush_i,
  input  logic              ack_i,
  output logic              ready_o,
  output logic [ADDR_W-1:0] vlx_addr_o,
  output logic [7:0]        dat_o,
  output logic              store_byte_o,
  output logic              last_byte_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] ROOM_MAX = (PW+1)'(FIFO_DEPTH - 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [38:0]       acc_q, acc_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;
  logic [7:0]        fifo_q [FIFO_DEPTH];

  logic [5:0]  len_eff;
  logic [31:0] dat_mask;
  logic [38:0] acc_app;
  logic [7:0]  top_byte, pad_byte, enq_byte;
  logic [3:0]  pad_n;
  logic        ready, set_addr, push_acc, flush_acc, pop, room;
  logic        take_top, take_pad, enq0, enq1;

  always_comb begin
    len_eff   = (len_i > 6'd32) ? 6'd32 : len_i;
    dat_mask  = 32'hFFFF_FFFF >> (6'd32 - len_eff);
    acc_app   = (acc_q << len_eff) | 39'(dat_i & dat_mask);
    top_byte  = 8'(acc_q >> (cnt_q - 6'd8));
    pad_n     = 4'(6'd8 - cnt_q);
    // Residual bits are left-justified in the byte and the tail filled with 1s.
    pad_byte  = (acc_q[7:0] << pad_n) | ~(8'hFF << pad_n);
    ready     = (cnt_q < 6'd8) && (state_q == ST_IDLE || state_q == ST_RUN);
    set_addr  = set_init_addr_i && (state_q == ST_IDLE);
    push_acc  = push_i && ready && !set_addr && (len_eff != 6'd0);
    flush_acc = flush_i && ready && !set_addr;
    pop       = ack_i && (count_q != '0);
    room      = (count_q <= ROOM_MAX);
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    take_top = 1'b0;
    take_pad = 1'b0;
    enq_byte = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (push_acc) begin
          acc_d   = acc_app;
          cnt_d   = cnt_q + len_eff;
          state_d = flush_acc ? ST_FLUSH : ST_RUN;
        end else if (flush_acc) begin
          done_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (push_acc) begin
          acc_d = acc_app;
          cnt_d = cnt_q + len_eff;
        end
        if (flush_acc) state_d = ST_FLUSH;
        take_top = (cnt_q >= 6'd8) && room;
      end
      ST_FLUSH: begin
        if (cnt_q >= 6'd8) begin
          take_top = room;
        end else if (cnt_q != 6'd0) begin
          take_pad = room;
        end else if (count_q == '0 || (count_q == (PW+1)'(1) && pop)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        if (count_q == '0 || (count_q == (PW+1)'(1) && pop)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
    if (take_top) begin
      enq_byte = top_byte;
      cnt_d    = cnt_q - 6'd8;
    end else if (take_pad) begin
      enq_byte = pad_byte;
      cnt_d    = 6'd0;
    end
  end

  always_comb begin
    enq0     = take_top || take_pad;
    enq1     = STUFF_EN && enq0 && (enq_byte == 8'hFF);
    wr_ptr_d = wr_ptr_q + PW'(enq0) + PW'(enq1);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + (PW+1)'(enq0) + (PW+1)'(enq1) - (PW+1)'(pop);
    addr_d   = addr_q;
    if (set_addr)  addr_d = dat_i[ADDR_W-1:0];
    else if (pop)  addr_d = addr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      done_q   <= done_d;
    end
  end

  // Storage needs no reset: occupancy gates every observable read.
  always_ff @(posedge clk_i) begin
    if (enq0) fifo_q[wr_ptr_q] <= enq_byte;
    if (enq1) fifo_q[wr_ptr_q + PW'(1)] <= 8'h00;
  end

  assign ready_o      = rst_i && ready;
  assign store_byte_o = (count_q != '0);
  assign dat_o        = store_byte_o ? fifo_q[rd_ptr_q] : 8'h00;
  assign vlx_addr_o   = addr_q;
  assign last_byte_o  = (count_q == (PW+1)'(1)) &&
                        (state_q == ST_DRAIN || (state_q == ST_FLUSH && cnt_q == 6'd0));
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;

endmodule
`default_nettype wire
